// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Holds the default NOP word, the deepest supported pipeline and the
// per-stage response record carried down the fetch pipeline.
package inst_mem_pkg;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h00000013;  // addi x0,x0,0
  localparam int          MAX_LATENCY      = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] data;
    logic        misalign;
    logic        oob;
  } stage_t;

endpackage

// File: rtl/inst_mem_array.sv
// Instruction word storage: one write port, one combinational read port.
// Read latency 0; a write to the word being read is forwarded (write-first).
// No backpressure; contents are never reset.
module inst_mem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_dat,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_dat
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // store program words; storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_dat;
    end
  end

  // combinational read, forwarding a same-cycle write to the same word
  always_comb begin
    rd_dat = mem_q[rd_idx];
    if (wr_en && (wr_idx == rd_idx)) begin
      rd_dat = wr_dat;
    end
  end

endmodule

// File: rtl/inst_mem_resp.sv
// Instruction fetch responder: returns {inst, pc, misalign, oob} LATENCY cycles after a request.
// Latency: LATENCY edges (1..4); one request per cycle; flush and rst kill everything in flight.
// No backpressure. Optional counters enabled by INST_MEM_STATS_EN.
module inst_mem_resp
  import inst_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] NOP_INST    = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] pc,
  input  logic        flush,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        misalign,
  output logic        oob
`ifdef INST_MEM_STATS_EN
  ,
  output logic [31:0] req_cnt,
  output logic [31:0] kill_cnt,
  output logic [31:0] err_cnt
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [AW-1:0] fetch_idx;
  logic          fetch_mis;
  logic          fetch_oob;
  logic          load_ok;
  logic          load_lsb_unused;
  logic [31:0]   rd_dat;
  stage_t        req;
  stage_t [LATENCY-1:0] stage_q;
  stage_t [LATENCY-1:0] stage_d;
  stage_t        last;

  assign fetch_idx       = pc[AW+1:2];
  assign fetch_mis       = (pc[1:0] != 2'b00);
  assign fetch_oob       = |pc[31:AW+2];
  // out-of-range loads are dropped rather than aliased into the array
  assign load_ok         = load_we & ~(|load_addr[31:AW+2]);
  assign load_lsb_unused = ^load_addr[1:0];

  inst_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk   (clk),
    .wr_en (load_ok),
    .wr_idx(load_addr[AW+1:2]),
    .wr_dat(load_data),
    .rd_idx(fetch_idx),
    .rd_dat(rd_dat)
  );

  // build the response record for the request presented this cycle
  always_comb begin
    req          = '0;
    req.valid    = 1'b1;
    req.pc       = pc;
    req.misalign = fetch_mis;
    req.oob      = fetch_oob;
    req.data     = (fetch_mis || fetch_oob) ? NOP_INST : rd_dat;
  end

  // advance the pipeline; bubbles, flush and reset all insert all-zero records
  always_comb begin
    stage_d = '0;
    if (!rst && !flush) begin
      stage_d[0] = ce ? req : '0;
      for (int i = 1; i < LATENCY; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  // pipeline registers
  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  assign last       = stage_q[LATENCY-1];
  assign inst_valid = last.valid;
  assign inst       = last.valid ? last.data : NOP_INST;
  assign inst_pc    = last.pc;
  assign misalign   = last.valid & last.misalign;
  assign oob        = last.valid & last.oob;

`ifdef INST_MEM_STATS_EN
  logic [31:0] req_cnt_q,  req_cnt_d;
  logic [31:0] kill_cnt_q, kill_cnt_d;
  logic [31:0] err_cnt_q,  err_cnt_d;
  logic [31:0] kill_inc;

  // kill count covers every valid stage plus the request sampled on the flush edge;
  // errors are counted as the response enters the output stage
  always_comb begin
    req_cnt_d  = req_cnt_q;
    kill_cnt_d = kill_cnt_q;
    err_cnt_d  = err_cnt_q;
    kill_inc   = {31'b0, ce};
    for (int i = 0; i < LATENCY; i++) begin
      kill_inc = kill_inc + {31'b0, stage_q[i].valid};
    end
    if (rst) begin
      req_cnt_d  = '0;
      kill_cnt_d = '0;
      err_cnt_d  = '0;
    end else begin
      if (ce && !flush) begin
        req_cnt_d = req_cnt_q + 32'd1;
      end
      if (flush) begin
        kill_cnt_d = kill_cnt_q + kill_inc;
      end
      if (stage_d[LATENCY-1].valid && (stage_d[LATENCY-1].misalign || stage_d[LATENCY-1].oob)) begin
        err_cnt_d = err_cnt_q + 32'd1;
      end
    end
  end

  // counter registers
  always_ff @(posedge clk) begin
    req_cnt_q  <= req_cnt_d;
    kill_cnt_q <= kill_cnt_d;
    err_cnt_q  <= err_cnt_d;
  end

  assign req_cnt  = req_cnt_q;
  assign kill_cnt = kill_cnt_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_inst_mem_resp.sv
// Bench for inst_mem_resp: three instances (LATENCY 1, 2, 3) share one stimulus stream.
// A table of directed vectors, hand-written multi-cycle sequences and a random phase
// are all checked against a schedule-based reference model.
module tb_inst_mem_resp;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, ce, flush, load_we;
  logic [31:0] pc, load_addr, load_data;

  logic [2:0]        o_vld, o_mis, o_oob;
  logic [2:0][31:0]  o_inst, o_pc;
`ifdef INST_MEM_STATS_EN
  logic [2:0][31:0]  s_req, s_kill, s_err;
`endif

  always #5 clk = ~clk;

  inst_mem_resp #(.DEPTH_WORDS(256), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .ce(ce), .pc(pc), .flush(flush),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .inst_valid(o_vld[0]), .inst(o_inst[0]), .inst_pc(o_pc[0]),
    .misalign(o_mis[0]), .oob(o_oob[0])
`ifdef INST_MEM_STATS_EN
    , .req_cnt(s_req[0]), .kill_cnt(s_kill[0]), .err_cnt(s_err[0])
`endif
  );

  inst_mem_resp #(.DEPTH_WORDS(256), .LATENCY(2)) u2 (
    .clk(clk), .rst(rst), .ce(ce), .pc(pc), .flush(flush),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .inst_valid(o_vld[1]), .inst(o_inst[1]), .inst_pc(o_pc[1]),
    .misalign(o_mis[1]), .oob(o_oob[1])
`ifdef INST_MEM_STATS_EN
    , .req_cnt(s_req[1]), .kill_cnt(s_kill[1]), .err_cnt(s_err[1])
`endif
  );

  inst_mem_resp #(.DEPTH_WORDS(256), .LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .ce(ce), .pc(pc), .flush(flush),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .inst_valid(o_vld[2]), .inst(o_inst[2]), .inst_pc(o_pc[2]),
    .misalign(o_mis[2]), .oob(o_oob[2])
`ifdef INST_MEM_STATS_EN
    , .req_cnt(s_req[2]), .kill_cnt(s_kill[2]), .err_cnt(s_err[2])
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  typedef struct {
    bit          v;
    logic [31:0] pc;
    logic [31:0] data;
    bit          mis;
    bit          oob;
  } exp_t;

  exp_t        sched [3][8];   // expected response, indexed by the edge it becomes visible
  logic [31:0] mem_m [256];
  int          lat [3] = '{1, 2, 3};
  bit          last_v [3];
  bit          rst_edge;
  int          e = 0;
  logic [31:0] m_req [3];
  logic [31:0] m_kill [3];
  logic [31:0] m_err [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %h expected %h", nm, e, act, exp);
    end
  endtask

  task automatic clear_sched(input int d);
    for (int s = 0; s < 8; s++) sched[d][s].v = 1'b0;
  endtask

  // apply the rules for the upcoming edge using the inputs currently driven
  task automatic model_edge();
    exp_t r;
    int   pend;
    r.v   = 1'b1;
    r.pc  = pc;
    r.mis = (pc[1:0] != 2'b00);
    r.oob = (pc[31:10] != 22'd0);
    if (r.mis || r.oob) r.data = NOP;
    else if (load_we && load_addr[31:10] == 22'd0 && load_addr[9:2] == pc[9:2]) r.data = load_data;
    else r.data = mem_m[pc[9:2]];
    if (load_we && load_addr[31:10] == 22'd0) mem_m[load_addr[9:2]] = load_data;
    rst_edge = rst;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        clear_sched(d);
        m_req[d] = 0; m_kill[d] = 0; m_err[d] = 0;
      end else if (flush) begin
        pend = (last_v[d] ? 1 : 0) + (ce ? 1 : 0);
        for (int s = 0; s < 8; s++) if (sched[d][s].v) pend++;
        m_kill[d] = m_kill[d] + pend;
        clear_sched(d);
      end else if (ce) begin
        sched[d][(e + lat[d] - 1) % 8] = r;
        m_req[d] = m_req[d] + 1;
      end
    end
  endtask

  // one clock: model, edge, then compare every instance away from the edge
  task automatic step();
    exp_t x;
    int   slot;
    model_edge();
    @(posedge clk);
    #1;
    slot = e % 8;
    for (int d = 0; d < 3; d++) begin
      x = sched[d][slot];
      sched[d][slot].v = 1'b0;
      if (x.v) begin
        chk($sformatf("L%0d inst_valid", lat[d]), {31'b0, o_vld[d]}, 32'd1);
        chk($sformatf("L%0d inst", lat[d]), o_inst[d], x.data);
        chk($sformatf("L%0d inst_pc", lat[d]), o_pc[d], x.pc);
        chk($sformatf("L%0d misalign", lat[d]), {31'b0, o_mis[d]}, {31'b0, x.mis});
        chk($sformatf("L%0d oob", lat[d]), {31'b0, o_oob[d]}, {31'b0, x.oob});
        if (x.mis || x.oob) m_err[d] = m_err[d] + 1;
      end else begin
        chk($sformatf("L%0d idle inst_valid", lat[d]), {31'b0, o_vld[d]}, 32'd0);
        chk($sformatf("L%0d idle inst", lat[d]), o_inst[d], NOP);
        chk($sformatf("L%0d idle flags", lat[d]), {30'b0, o_mis[d], o_oob[d]}, 32'd0);
        if (rst_edge) chk($sformatf("L%0d reset inst_pc", lat[d]), o_pc[d], 32'd0);
      end
      last_v[d] = x.v;
`ifdef INST_MEM_STATS_EN
      chk($sformatf("L%0d req_cnt", lat[d]), s_req[d], m_req[d]);
      chk($sformatf("L%0d kill_cnt", lat[d]), s_kill[d], m_kill[d]);
      chk($sformatf("L%0d err_cnt", lat[d]), s_err[d], m_err[d]);
`endif
    end
    e++;
  endtask

  task automatic drive(input bit r, input bit c, input logic [31:0] p, input bit f,
                       input bit we, input logic [31:0] la, input logic [31:0] ld);
    rst = r; ce = c; pc = p; flush = f; load_we = we; load_addr = la; load_data = ld;
  endtask

  // ---------------- directed table (expected values for the LATENCY=1 instance) ----------------
  typedef struct {
    bit          rst, ce, flush, we;
    logic [31:0] pc, la, ld;
    bit          x_vld;
    logic [31:0] x_inst, x_pc;
    bit          x_mis, x_oob;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [31:0] tmp;
    int          r;
`ifdef INST_MEM_STATS_EN
    logic [31:0] k0;
`endif
    for (int d = 0; d < 3; d++) begin
      clear_sched(d);
      last_v[d] = 1'b0;
      m_req[d] = 0; m_kill[d] = 0; m_err[d] = 0;
    end

    //            rst ce  fl  we  pc            la            ld            vld inst          pc            mis oob
    tbl[0]  = '{0, 1, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h11111111, 32'h0,        0, 0};
    tbl[1]  = '{0, 1, 0, 0, 32'h4,        32'h0,        32'h0,        1, 32'h22222222, 32'h4,        0, 0};
    tbl[2]  = '{0, 1, 0, 0, 32'h8,        32'h0,        32'h0,        1, 32'h33333333, 32'h8,        0, 0};
    tbl[3]  = '{0, 1, 0, 0, 32'hC,        32'h0,        32'h0,        1, 32'h44444444, 32'hC,        0, 0};
    tbl[4]  = '{0, 1, 0, 0, 32'h6,        32'h0,        32'h0,        1, NOP,          32'h6,        1, 0};
    tbl[5]  = '{0, 1, 0, 0, 32'h400,      32'h0,        32'h0,        1, NOP,          32'h400,      0, 1};
    tbl[6]  = '{0, 1, 0, 0, 32'h402,      32'h0,        32'h0,        1, NOP,          32'h402,      1, 1};
    tbl[7]  = '{0, 1, 0, 1, 32'h8,        32'h8,        32'hDEADBEEF, 1, 32'hDEADBEEF, 32'h8,        0, 0};
    tbl[8]  = '{0, 0, 0, 0, 32'h8,        32'h0,        32'h0,        0, NOP,          32'h0,        0, 0};
    tbl[9]  = '{0, 1, 0, 0, 32'h8,        32'h0,        32'h0,        1, 32'hDEADBEEF, 32'h8,        0, 0};
    tbl[10] = '{0, 1, 1, 0, 32'h4,        32'h0,        32'h0,        0, NOP,          32'h0,        0, 0};
    tbl[11] = '{0, 1, 0, 0, 32'h3FC,      32'h0,        32'h0,        1, 32'h5A0000FF, 32'h3FC,      0, 0};
    tbl[12] = '{1, 1, 0, 0, 32'h0,        32'h0,        32'h0,        0, NOP,          32'h0,        0, 0};
    tbl[13] = '{0, 1, 0, 1, 32'h4,        32'h404,      32'hCAFEF00D, 1, 32'h22222222, 32'h4,        0, 0};
    tbl[14] = '{0, 1, 0, 0, 32'h4,        32'h0,        32'h0,        1, 32'h22222222, 32'h4,        0, 0};

    // reset, with the whole array loaded while rst is held
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      drive(1, 0, 0, 0, 1, i * 4, 32'h5A000000 + i);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 1, i * 4, 32'h11111111 * (i + 1));
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    step();

    // directed table
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rst, tbl[i].ce, tbl[i].pc, tbl[i].flush, tbl[i].we, tbl[i].la, tbl[i].ld);
      step();
      chk($sformatf("tbl%0d inst_valid", i), {31'b0, o_vld[0]}, {31'b0, tbl[i].x_vld});
      chk($sformatf("tbl%0d inst", i), o_inst[0], tbl[i].x_inst);
      if (tbl[i].x_vld || tbl[i].rst) chk($sformatf("tbl%0d inst_pc", i), o_pc[0], tbl[i].x_pc);
      chk($sformatf("tbl%0d flags", i), {30'b0, o_mis[0], o_oob[0]}, {30'b0, tbl[i].x_mis, tbl[i].x_oob});
    end

    // flush on LATENCY=3 kills both in-flight requests and the one sampled that edge
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step();
`ifdef INST_MEM_STATS_EN
    k0 = s_kill[2];
`endif
    drive(0, 1, 32'h0, 0, 0, 0, 0); step();
    drive(0, 1, 32'h4, 0, 0, 0, 0); step();
    drive(0, 1, 32'h8, 1, 0, 0, 0); step();
`ifdef INST_MEM_STATS_EN
    chk("flush L3 kill_cnt delta", s_kill[2] - k0, 32'd3);
`endif
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush L3 quiet inst_valid", {31'b0, o_vld[2]}, 32'd0);
    end
    // redirected PC right after a flush is accepted normally
    drive(0, 1, 32'h4, 1, 0, 0, 0); step();
    drive(0, 1, 32'hC, 0, 0, 0, 0); step();
    chk("post-flush L1 inst", o_inst[0], 32'h44444444);

    // reset mid-stream on LATENCY=2; memory survives
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step();
    drive(0, 1, 32'h0, 0, 0, 0, 0); step();
    drive(0, 1, 32'h4, 0, 0, 0, 0); step();
    drive(1, 1, 32'h8, 0, 0, 0, 0); step();
    chk("rst L2 inst_valid", {31'b0, o_vld[1]}, 32'd0);
    chk("rst L2 inst_pc", o_pc[1], 32'd0);
    drive(0, 1, 32'h0, 0, 0, 0, 0); step();
    drive(0, 0, 32'h0, 0, 0, 0, 0); step();
    chk("post-rst L2 inst_valid", {31'b0, o_vld[1]}, 32'd1);
    chk("post-rst L2 inst", o_inst[1], 32'h11111111);

    // ce toggling on LATENCY=1 leaves a one-cycle bubble
    drive(0, 1, 32'h0, 0, 0, 0, 0); step();
    chk("ce 1 inst", o_inst[0], 32'h11111111);
    drive(0, 0, 32'h4, 0, 0, 0, 0); step();
    chk("ce 0 inst_valid", {31'b0, o_vld[0]}, 32'd0);
    chk("ce 0 inst", o_inst[0], NOP);
    drive(0, 1, 32'h8, 0, 0, 0, 0); step();
    chk("ce 1 again inst", o_inst[0], 32'hDEADBEEF);

    // random phase
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 99) < 2);
      flush     = ($urandom_range(0, 99) < 6);
      ce        = ($urandom_range(0, 99) < 80);
      r         = $urandom_range(0, 15);
      tmp       = $urandom;
      if (r < 12)       pc = {22'd0, tmp[7:0], 2'b00};
      else if (r < 14)  pc = {22'd0, tmp[7:0], 2'b00} | 32'($urandom_range(1, 3));
      else if (r == 14) pc = (tmp | 32'h00000400) & 32'hFFFFFFFC;
      else              pc = tmp;
      load_we   = ($urandom_range(0, 99) < 25);
      load_data = $urandom;
      tmp       = $urandom;
      if ($urandom_range(0, 3) == 0) load_addr = pc;
      else if ($urandom_range(0, 4) == 0) load_addr = tmp | 32'h00000400;
      else load_addr = {22'd0, tmp[9:0]};
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_mem_resp.md
Name: inst_mem_resp

Overview:
Instruction-memory responder for the PC/fetch interface. It samples the `ce`/`pc` request every cycle and returns the instruction word, tagged with its PC, to decode after a fixed, parameterised latency. It kills in-flight fetches on a branch `flush` and flags misaligned or out-of-range fetches. A load port lets the bench or boot logic write program words.

Parameters:
DEPTH_WORDS, 256, number of 32-bit instruction words; power of two.
LATENCY, 1, cycles from request sample to response; legal range 1..4.
NOP_INST, 32'h00000013, word driven on `inst` when no valid instruction is available (addi x0,x0,0).

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
ce  in  1  fetch enable from PC generator; request valid when 1
pc  in  32  fetch byte address
flush  in  1  branch taken this cycle; discard all in-flight and current requests
load_we  in  1  program-load write strobe
load_addr  in  32  byte address of word to write; bits [1:0] ignored
load_data  in  32  word to write
inst_valid  out  1  response valid
inst  out  32  fetched instruction, or NOP_INST
inst_pc  out  32  PC of the returned instruction
misalign  out  1  response PC had pc[1:0] != 0; qualified by inst_valid
oob  out  1  response word index >= DEPTH_WORDS; qualified by inst_valid

Behaviour:
- AW = log2(DEPTH_WORDS). Word index = pc[AW+1:2]. Out of range when pc[31:AW+2] != 0.
- Request accepted at posedge when rst=0, ce=1, flush=0.
- Response pipeline: LATENCY stages, each holding {valid, pc, data, misalign, oob}.
  - Stage 0 loads at the accepting edge.
  - Outputs are driven from the last stage.
  - A request accepted at edge t appears on the outputs after edge t+LATENCY-1, so it is visible during cycle t+LATENCY-1..t+LATENCY. LATENCY=1 gives a registered read, visible the cycle after the request.
- Throughput: one request per cycle, no backpressure, no stalls.
- Reset:
  - All stage valid bits clear.
  - Outputs: inst_valid=0, inst=NOP_INST, inst_pc=0, misalign=0, oob=0.
  - Memory contents are not reset.
  - Reset mid-stream discards every in-flight request.
- ce=0 while out of reset: a bubble (valid=0) enters stage 0; older stages keep advancing.
- flush=1 at an edge:
  - All stage valid bits clear, including the request sampled that edge.
  - Next cycle inst_valid=0, inst=NOP_INST.
  - The redirected PC presented the following cycle is accepted normally.
- Invalid output: whenever inst_valid=0, inst=NOP_INST and misalign=oob=0.
- Misaligned request: response is valid, with inst=NOP_INST and misalign=1. The array is not read. oob is still evaluated.
- Out-of-range request: response is valid, with inst=NOP_INST and oob=1. No wrap-around into the array.
- If both misalign and oob apply, both flags are set.
- Load port:
  - load_we=1 writes load_data to word load_addr[AW+1:2] at the edge.
  - Out-of-range load addresses are silently dropped.
  - A load may occur in any cycle, including during fetch and during rst.
- Same-word read and write in one cycle: write-first; the fetch returns load_data.

Optional Feature:
INST_MEM_STATS_EN:
- Defined:
  - Adds outputs `req_cnt[31:0]`: accepted requests.
  - Adds `kill_cnt[31:0]`: valid stage entries discarded by flush, summed per flush edge.
  - Adds `err_cnt[31:0]`: responses with misalign or oob.
  - All counters clear on rst and wrap modulo 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package inst_mem_pkg:
  - NOP_INST default constant.
  - Max-LATENCY constant (4).
  - Typedef for the stage record {valid, pc, data, misalign, oob}.
- Sub-module inst_mem_array:
  - DEPTH_WORDS x 32 storage.
  - One write port and one combinational read port with write-first bypass.
- inst_mem_resp owns the request checks, the pipeline, flush and the counters.

Test Plan:
- Load words 0..3 = 32'h11111111..32'h44444444. Hold ce=1 with pc 0,4,8,12 on consecutive cycles, LATENCY=1. Required: inst_valid=1 one cycle after each request, inst/inst_pc = 11111111/0, 22222222/4, 33333333/8, 44444444/12.
- LATENCY=3, pc=0,4,8. Assert flush on the edge sampling pc=8. Required: only pc=0 and pc=4 could complete, but both are killed since they are in flight at the flush edge. inst_valid stays 0 for 3 cycles; with stats, kill_cnt=3.
- pc=32'h00000006. Required: inst_valid=1, inst=00000013, misalign=1, oob=0. pc=32'h00000400 with DEPTH=256 gives oob=1, inst=00000013.
- Write load_addr=8, load_data=DEADBEEF in the same cycle as a fetch of pc=8. Required: response inst=DEADBEEF.
- Stream pc 0,4,8 with LATENCY=2 and assert rst for one cycle mid-stream. Required: next cycle inst_valid=0, inst_pc=0. Memory retains its loaded words; a fetch after reset returns them.
- Toggle ce 1,0,1 with pc 0,4,8. Required: valid responses for pc 0 and 8 only, with a one-cycle bubble of inst_valid=0 and inst=NOP_INST between them.
